// File: rtl/frame_commit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : frame_commit_scheduler
//  Purpose  : Shadow/active coordinate register file with vblank-aligned
//             commit. Software writes the shadow copy through a req/ack
//             handshake and requests a commit; the copy to the active set
//             runs only in vertical blank so no frame mixes old and new
//             sprite positions. Also provides frame tick, frame counter and
//             a saturating count of frames that passed without a commit.
//  Options  : FRAME_COMMIT_AUTO_EN - when defined, any accepted write marks
//             the shadow dirty and the next vblank commits it automatically.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_commit_scheduler #(
  parameter int NUM_REGS = 16,
  parameter int COORD_W  = 11,
  parameter int V_ACTIVE = 480
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [COORD_W-1:0]            DrawY,
  input  logic                          wr_req,
  input  logic [$clog2(NUM_REGS)-1:0]   wr_idx,
  input  logic [COORD_W-1:0]            wr_data,
  output logic                          wr_ack,
  input  logic                          commit_req,
  output logic                          commit_pending,
  output logic                          commit_done,
  output logic                          busy,
  output logic [NUM_REGS*COORD_W-1:0]   active_flat,
  output logic                          frame_tick,
  output logic [15:0]                   frame_count,
  output logic [7:0]                    stale_frames
);

  localparam int                   IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [COORD_W-1:0]   V_LINE   = COORD_W'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COPY  = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     copy_idx;
  logic                 rearm;
  logic [COORD_W-1:0]   prev_y;
  logic [COORD_W-1:0]   shadow [NUM_REGS];
  logic [COORD_W-1:0]   active [NUM_REGS];

  logic tick_now;
  logic wr_accept;
  logic auto_go;
  logic start_copy;

  // Rising crossing of the first non-visible line marks vblank start.
  assign tick_now  = (prev_y < V_LINE) && (DrawY >= V_LINE);
  // A new request is taken only when the previous ack has retired; COPY stalls it.
  assign wr_accept = wr_req && !wr_ack && (state != S_COPY);
  // Copy begins on the tick when armed, or when idle with auto-commit pending.
  assign start_copy = frame_tick &&
                      ((state == S_ARMED) || ((state == S_IDLE) && auto_go));

  assign commit_pending = (state == S_ARMED);
  assign busy           = (state == S_COPY);

`ifdef FRAME_COMMIT_AUTO_EN
  logic dirty;

  // Dirty tracks shadow writes not yet committed; clearing at copy start wins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dirty <= 1'b0;
    end else if (start_copy) begin
      dirty <= 1'b0;
    end else if (wr_accept) begin
      dirty <= 1'b1;
    end
  end

  assign auto_go = dirty;
`else
  assign auto_go = 1'b0;
`endif

  // Vblank detection and the free-running frame counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prev_y      <= '0;
      frame_tick  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      prev_y     <= DrawY;
      frame_tick <= tick_now;
      if (tick_now) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Shadow write port with one-cycle acknowledge; out-of-range indices match no entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ack <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      wr_ack <= wr_accept;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_accept && (wr_idx == IDX_W'(i))) begin
          shadow[i] <= wr_data;
        end
      end
    end
  end

  // Commit FSM: arms on request, copies one register per cycle during vblank.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      copy_idx     <= '0;
      rearm        <= 1'b0;
      commit_done  <= 1'b0;
      stale_frames <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        active[i] <= '0;
      end
    end else begin
      commit_done <= 1'b0;

      if (frame_tick && !start_copy && (stale_frames != 8'hFF)) begin
        stale_frames <= stale_frames + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (start_copy) begin
            state    <= S_COPY;
            copy_idx <= '0;
            rearm    <= 1'b0;
          end else if (commit_req) begin
            state <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (start_copy) begin
            state    <= S_COPY;
            copy_idx <= '0;
            rearm    <= 1'b0;
          end
        end

        S_COPY: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (copy_idx == IDX_W'(i)) begin
              active[i] <= shadow[i];
            end
          end
          if (commit_req) begin
            rearm <= 1'b1;
          end
          if (copy_idx == LAST_IDX) begin
            state       <= (rearm || commit_req) ? S_ARMED : S_IDLE;
            rearm       <= 1'b0;
            copy_idx    <= '0;
            commit_done <= 1'b1;
          end else begin
            copy_idx <= copy_idx + IDX_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Flatten the active set for color_mapper.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign active_flat[gi*COORD_W +: COORD_W] = active[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_commit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_commit_scheduler
//  Purpose  : Self-checking bench for frame_commit_scheduler. A bench-side
//             model of shadow/active registers predicts each commit; the
//             expected active image is queued when the vblank is driven and
//             compared when commit_done appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_commit_scheduler;

  localparam int NR     = 16;
  localparam int CW     = 11;
  localparam int IW     = $clog2(NR);
  localparam int FLAT_W = NR * CW;
`ifdef FRAME_COMMIT_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic              Clk;
  logic              Reset;
  logic [CW-1:0]     DrawY;
  logic              wr_req;
  logic [IW-1:0]     wr_idx;
  logic [CW-1:0]     wr_data;
  logic              wr_ack;
  logic              commit_req;
  logic              commit_pending;
  logic              commit_done;
  logic              busy;
  logic [FLAT_W-1:0] active_flat;
  logic              frame_tick;
  logic [15:0]       frame_count;
  logic [7:0]        stale_frames;

  frame_commit_scheduler #(
    .NUM_REGS (NR),
    .COORD_W  (CW),
    .V_ACTIVE (480)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .DrawY          (DrawY),
    .wr_req         (wr_req),
    .wr_idx         (wr_idx),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .commit_req     (commit_req),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .busy           (busy),
    .active_flat    (active_flat),
    .frame_tick     (frame_tick),
    .frame_count    (frame_count),
    .stale_frames   (stale_frames)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model state
  logic [CW-1:0]     m_shadow [NR];
  logic [CW-1:0]     m_active [NR];
  bit                m_armed;
  bit                m_dirty;
  int                m_stale;
  int                m_frames;
  logic [FLAT_W-1:0] exp_q [$];

  int n_checks;
  int n_pass;

  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [FLAT_W-1:0] flat_of();
    logic [FLAT_W-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*CW +: CW] = m_active[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_armed  = 0;
    m_dirty  = 0;
    m_stale  = 0;
    m_frames = 0;
    exp_q.delete();
  endtask

  task automatic tick_clk();
    @(posedge Clk);
    #1;
  endtask

  // Shadow write through the handshake, optionally with a same-cycle commit.
  task automatic do_write(input int idx, input logic [CW-1:0] data, input bit with_commit);
    bit acked;
    acked      = 0;
    wr_req     = 1'b1;
    wr_idx     = IW'(idx);
    wr_data    = data;
    commit_req = with_commit;
    for (int n = 0; n < 20; n++) begin
      tick_clk();
      commit_req = 1'b0;
      if (wr_ack) begin
        acked = 1;
        break;
      end
    end
    wr_req = 1'b0;
    check_value("wr_ack_seen", 256'(acked), 256'(1));
    m_shadow[idx] = data;
    m_dirty = 1;
    if (with_commit) m_armed = 1;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick_clk();
    commit_req = 1'b0;
    m_armed = 1;
    check_value("pending_after_req", 256'(commit_pending), 256'(1));
  endtask

  // Drive DrawY across the visible boundary; returns in the tick cycle T.
  task automatic do_vblank(input bit quiet, output bit go);
    DrawY = 11'd479;
    tick_clk();
    DrawY = 11'd480;
    tick_clk();
    m_frames = (m_frames + 1) & 16'hFFFF;
    if (!quiet) begin
      check_value("frame_tick", 256'(frame_tick), 256'(1));
      check_value("frame_count", 256'(frame_count), 256'(m_frames));
    end
    go = m_armed || (AUTO && m_dirty);
    if (go) begin
      for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
      exp_q.push_back(flat_of());
      m_armed = 0;
      m_dirty = 0;
    end else if (m_stale < 255) begin
      m_stale++;
    end
    DrawY = 11'd10;
  endtask

  // Follow a copy from cycle T until commit_done; optional rearm, stalled write and probe.
  task automatic run_copy(input int rearm_k, input int wr_k, input int probe_idx,
                          input logic [CW-1:0] p_old, input logic [CW-1:0] p_new);
    int k;
    bit done;
    logic [FLAT_W-1:0] exp;
    done = 0;
    for (k = 1; k <= 40; k++) begin
      tick_clk();
      commit_req = (k == rearm_k);
      if (k == wr_k) begin
        wr_req  = 1'b1;
        wr_idx  = IW'(5);
        wr_data = 11'h2AA;
      end
      if (wr_k > 0 && k >= wr_k) check_value("stall_no_ack", 256'(wr_ack), 256'(0));
      if (probe_idx >= 0 && k == probe_idx + 1)
        check_value("probe_before", 256'(active_flat[probe_idx*CW +: CW]), 256'(p_old));
      if (probe_idx >= 0 && k == probe_idx + 2)
        check_value("probe_after", 256'(active_flat[probe_idx*CW +: CW]), 256'(p_new));
      if (k == 1) check_value("busy_in_copy", 256'(busy), 256'(1));
      if (commit_done) begin
        done = 1;
        break;
      end
    end
    commit_req = 1'b0;
    check_value("commit_done_seen", 256'(done), 256'(1));
    check_value("commit_latency", 256'(k), 256'(NR + 1));
    check_value("busy_after_copy", 256'(busy), 256'(0));
    if (rearm_k > 0) begin
      check_value("rearmed_pending", 256'(commit_pending), 256'(1));
      m_armed = 1;
    end
    check_value("sb_nonempty", 256'(exp_q.size() > 0), 256'(1));
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check_value("commit_image", 256'(active_flat), 256'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit go;
    n_checks   = 0;
    n_pass     = 0;
    Reset      = 1'b1;
    DrawY      = 11'd100;
    wr_req     = 1'b0;
    wr_idx     = '0;
    wr_data    = '0;
    commit_req = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick_clk();
    check_value("rst_active", 256'(active_flat), 256'(0));
    check_value("rst_pending", 256'(commit_pending), 256'(0));
    check_value("rst_busy", 256'(busy), 256'(0));
    check_value("rst_done", 256'(commit_done), 256'(0));
    check_value("rst_tick", 256'(frame_tick), 256'(0));
    check_value("rst_frames", 256'(frame_count), 256'(0));
    check_value("rst_stale", 256'(stale_frames), 256'(0));
    Reset = 1'b0;
    tick_clk();
    check_value("rst_wr_ack", 256'(wr_ack), 256'(0));

    // Basic commit
    do_write(3, 11'h123, 1'b0);
    pulse_commit();
    do_vblank(1'b0, go);
    run_copy(-1, -1, 3, 11'h000, 11'h123);
    check_value("stale_basic", 256'(stale_frames), 256'(m_stale));

    // Write with no explicit commit across three vblanks
    do_write(0, 11'h050, 1'b0);
    for (int v = 0; v < 3; v++) begin
      do_vblank(1'b0, go);
      if (go) run_copy(-1, -1, 0, 11'h000, 11'h050);
    end
    tick_clk();
    check_value("stale_idle", 256'(stale_frames), 256'(m_stale));
    check_value("active_idle", 256'(active_flat), 256'(flat_of()));

    // Write held during COPY is stalled until the FSM returns to IDLE
    pulse_commit();
    do_vblank(1'b0, go);
    run_copy(-1, 2, 5, 11'h000, 11'h000);
    tick_clk();
    check_value("stall_ack_late", 256'(wr_ack), 256'(1));
    wr_req = 1'b0;
    m_shadow[5] = 11'h2AA;
    m_dirty = 1;
    check_value("stall_active", 256'(active_flat), 256'(flat_of()));

    // Commit during COPY rearms; next tick copies again
    pulse_commit();
    do_vblank(1'b0, go);
    run_copy(8, -1, 5, 11'h000, 11'h2AA);
    do_write(7, 11'h3FF, 1'b0);
    do_vblank(1'b0, go);
    run_copy(-1, -1, 7, 11'h000, 11'h3FF);

    // Commit together with a tick in IDLE only arms
    do_vblank(1'b0, go);
    commit_req = 1'b1;
    tick_clk();
    commit_req = 1'b0;
    m_armed = 1;
    check_value("same_cycle_busy", 256'(busy), 256'(0));
    check_value("same_cycle_pending", 256'(commit_pending), 256'(1));
    check_value("same_cycle_stale", 256'(stale_frames), 256'(m_stale));
    do_vblank(1'b0, go);
    run_copy(-1, -1, -1, 11'h000, 11'h000);

    // Reset in the middle of a copy
    do_write(9, 11'h155, 1'b0);
    pulse_commit();
    do_vblank(1'b0, go);
    repeat (6) tick_clk();
    Reset = 1'b1;
    #1;
    model_reset();
    check_value("midrst_active", 256'(active_flat), 256'(0));
    check_value("midrst_busy", 256'(busy), 256'(0));
    check_value("midrst_pending", 256'(commit_pending), 256'(0));
    check_value("midrst_frames", 256'(frame_count), 256'(0));
    tick_clk();
    Reset = 1'b0;
    tick_clk();
    check_value("midrst_wr_ack", 256'(wr_ack), 256'(0));
    do_write(2, 11'h2F0, 1'b1);
    check_value("wr_commit_pending", 256'(commit_pending), 256'(1));
    do_vblank(1'b0, go);
    run_copy(-1, -1, 2, 11'h000, 11'h2F0);

    // Stale counter saturation
    for (int v = 0; v < 260; v++) do_vblank(1'b1, go);
    tick_clk();
    check_value("stale_saturate", 256'(stale_frames), 256'(m_stale));
    check_value("frames_final", 256'(frame_count), 256'(m_frames));
    check_value("sb_drained", 256'(exp_q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_commit_scheduler.md
# frame_commit_scheduler

Frame-synchronous commit scheduler between the Nios II position/score PIO exports and `color_mapper`. Software writes sprite coordinates into a shadow register file through a req/ack handshake, then requests a commit. The block copies shadow to active registers only during vertical blank, so `color_mapper` never draws a frame with mixed old and new positions. It also provides a per-frame tick and frame/stale counters for game pacing.

## Interface
- `NUM_REGS`, 16: number of coordinate registers (x/y pairs for bird, pipes, text, score).
- `COORD_W`, 11: width of each register, matching `DrawX`/`DrawY`.
- `V_ACTIVE`, 480: first non-visible line.
- `Clk` in 1: 50 MHz system clock.
- `Reset` in 1: asynchronous, active-high.
- `DrawY` in COORD_W: current scan line from `vga_controller`.
- `wr_req` in 1: shadow write request; held high until `wr_ack`.
- `wr_idx` in $clog2(NUM_REGS): target register.
- `wr_data` in COORD_W: write value.
- `wr_ack` out 1: one-cycle write acknowledge.
- `commit_req` in 1: one-cycle pulse, "commit shadow at next vblank".
- `commit_pending` out 1: high in ARMED state.
- `commit_done` out 1: one-cycle pulse after the copy finishes.
- `busy` out 1: high in COPY state.
- `active_flat` out NUM_REGS*COORD_W: active registers; register i is at bits [i*COORD_W +: COORD_W].
- `frame_tick` out 1: one-cycle pulse at vblank start.
- `frame_count` out 16: frames since reset, wraps.
- `stale_frames` out 8: vblanks with no commit armed, saturating at 255.

## Operation
- **Vblank detect:** registered `DrawY` compare. `frame_tick` = previous `DrawY` < V_ACTIVE and current `DrawY` >= V_ACTIVE. `frame_count` increments on each tick, wrapping 0xFFFF→0.
- **FSM states:** IDLE, ARMED, COPY.
  - IDLE + `commit_req` → ARMED.
  - ARMED + `frame_tick` → COPY, with `copy_idx`=0.
  - COPY: `active[copy_idx] <= shadow[copy_idx]` each cycle. After `copy_idx`=NUM_REGS-1 → IDLE, with `commit_done` pulsed.
- **Writes:** accepted in IDLE and ARMED. When `wr_req` is sampled high and `wr_ack` was low the previous cycle, `shadow[wr_idx] <= wr_data` and `wr_ack` goes high for the next cycle. Back-to-back writes therefore take 2 cycles each.
  - In COPY, `wr_req` is stalled: no ack and no shadow change. The write completes after the return to IDLE.
- **Commit during COPY:** sets `rearm`. On leaving COPY the FSM enters ARMED instead of IDLE, and `commit_done` still pulses.
- **Commit in ARMED:** ignored; already armed.
- **Same-cycle events:**
  - `commit_req` together with `frame_tick` in IDLE → ARMED only; the copy happens next frame.
  - `wr_req` together with `commit_req` in IDLE → both accepted. The write precedes any copy.
- **Stale frames:** a `frame_tick` while not in ARMED increments `stale_frames` (saturating at 255).
- **Width rule:** `wr_idx` >= NUM_REGS is acked but discarded.

## Timing
- **Reset values:** all shadow and active registers 0; FSM IDLE; `rearm` 0; all outputs 0.
- **Reset mid-COPY:** active registers return to 0 immediately; a partial copy is not preserved.
- **Commit latency:** `frame_tick` in cycle T (ARMED) → copies in cycles T+1..T+NUM_REGS → `commit_done` and `busy`=0 in cycle T+NUM_REGS+1.
- **Copy visibility:** `active_flat` bits for index i change at the clock edge ending cycle T+1+i.
- **Write latency:** `wr_ack` one cycle after acceptance; the shadow value is visible at the same edge.
- A copy of at most 16 cycles fits far inside one line time, so no tick can arrive during COPY.

## Configuration
- `FRAME_COMMIT_AUTO_EN`:
  - **Defined:** a dirty flag is set by any accepted write and cleared when COPY starts. A `frame_tick` in IDLE with dirty=1 behaves as ARMED, entering COPY at T+1 without `commit_req`; that tick does not count as stale. `commit_req` still works as described above.
  - **Undefined:** commits occur only through `commit_req`; no dirty flag exists.

## Test plan
- **Reset:** assert `Reset` mid-frame → all outputs 0, `active_flat`=0, FSM IDLE, and `wr_ack` low the cycle after release.
- **Basic commit:** write idx 3=0x123, pulse `commit_req`, drive `DrawY` 479→480 → `commit_pending`=1 before the tick, active[3]=0x123 at T+4, `commit_done` at T+17, `frame_count`=1.
- **No commit (macro undefined):** write idx 0=0x050 with no commit, run 3 vblanks → active[0] stays 0, `stale_frames`=3. With the macro defined, active[0]=0x050 after the first tick and `stale_frames`=0.
- **Write stall:** hold `wr_req` (idx 5=0x2AA) from T+2 during COPY → no `wr_ack` until the cycle after `busy` falls; active[5] keeps its pre-write value and shadow[5]=0x2AA.
- **Commit during COPY:** pulse `commit_req` at T+8 → `commit_done` at T+17, then `commit_pending`=1. The next tick copies again.
- **Reset mid-COPY:** assert `Reset` at T+6 → active registers 0 and FSM IDLE. After release, a write plus commit plus tick completes normally.
